// File: rtl/dump_pkg.sv
// dump_pkg: shared state encoding and sizing constants for the memory dump reader
package dump_pkg;
  localparam int ADDR_W = 8;
  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS = 64;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_e;
endpackage

// File: rtl/mem_dump_reader_byte_assembler.sv
// byte_assembler: shifts captured bytes into a big-endian word and flags the last byte of each word
module byte_assembler
  import dump_pkg::*;
(
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    cap,
  input  logic [7:0]              din,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    last
);
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [1:0]              cnt_q, cnt_d;
  // earlier bytes move toward the MSBs so the lowest address ends up in 31:24
  always_comb begin
    word_d = cap ? {word_q[8*WORD_BYTES-9:0], din} : word_q;
    cnt_d  = cap ? cnt_q + 2'd1 : cnt_q;
  end
  // word and byte-count registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end
  assign word = word_q;
  assign last = cap && cnt_q == 2'(WORD_BYTES - 1);
endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads word_count 4-byte words from a byte RAM and presents them with a ready/valid handshake; MEM_DUMP_CHECKSUM_EN adds a running word checksum
module mem_dump_reader
  import dump_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [6:0]        word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [31:0]       dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [6:0]        count_q, count_d;
  logic [2:0]        phase_q, phase_d;
  logic              cap, last, handshake;
  logic              unused_low_bits;
  assign unused_low_bits = ^base_addr[1:0];
  assign mem_rd     = state_q == FETCH && phase_q < 3'(WORD_BYTES);
  assign cap        = state_q == FETCH && phase_q != 3'd0;
  assign mem_addr   = mem_rd ? addr_q + ADDR_W'(phase_q) : mem_addr_q;
  assign dout_addr  = addr_q;
  assign dout_valid = state_q == HOLD;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign handshake  = dout_valid && dout_ready;
  byte_assembler u_asm (
    .clk  (clk),
    .Reset(Reset),
    .cap  (cap),
    .din  (mem_data),
    .word (dout),
    .last (last)
  );
  // next-state, word address and remaining-count logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    phase_d    = state_q == FETCH ? phase_q + 3'd1 : 3'd0;
    mem_addr_d = mem_addr;
    unique case (state_q)
      IDLE: if (start) begin
        addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
        count_d = word_count > 7'(MAX_WORDS) ? 7'(MAX_WORDS) : word_count;
        state_d = word_count == 7'd0 ? DONE : FETCH;
      end
      FETCH: if (last) state_d = HOLD;
      HOLD: if (dout_ready) begin
        addr_d  = addr_q + ADDR_W'(WORD_BYTES);
        count_d = count_q - 7'd1;
        state_d = count_q == 7'd1 ? DONE : FETCH;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // control registers; reset abandons any dump in progress
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      count_q    <= '0;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
    end
  end
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  // sum restarts when a dump is accepted and accumulates each delivered word
  always_comb begin
    sum_d = (state_q == IDLE && start) ? 32'd0 : handshake ? sum_q + dout : sum_q;
  end
  // checksum register
  always_ff @(posedge clk) begin
    if (Reset) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: scoreboard bench for mem_dump_reader
module tb_mem_dump_reader;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [6:0]  word_count = '0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = '0;
  logic [31:0] dout;
  logic [7:0]  dout_addr;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [7:0]  ram [256];
  logic [39:0] sb [$];
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;

  mem_dump_reader dut (
    .clk(clk), .Reset(Reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .dout(dout), .dout_addr(dout_addr),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (mem_rd) rd_cnt++;
    if (done) done_cnt++;
    if (dout_valid && dout_ready) begin
      if (sb.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("word", dout, e[31:0]);
        chk("word_addr", {24'd0, dout_addr}, {24'd0, e[39:32]});
      end
    end
  end

  task automatic expect_words(input logic [7:0] base, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = {base[7:2], 2'b00} + 8'(4 * i);
      sb.push_back({a, ram[a], ram[a + 8'd1], ram[a + 8'd2], ram[a + 8'd3]});
    end
  endtask

  task automatic pulse_start(input logic [7:0] base, input logic [6:0] n);
    base_addr = base;
    word_count = n;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    bit got;
    got = 0;
    lat = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (lat == 0 && dout_valid) lat = c;
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_dump(input logic [7:0] base, input logic [6:0] n);
    int lat;
    expect_words(base, int'(n));
    pulse_start(base, n);
    wait_done(400, lat);
    chk("first_valid_latency", lat, 6);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, d0, lat;
    logic [31:0] snap;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 8; i++) ram[i] = 8'(8'h11 * (i + 1));
    ram[8'hFC] = 8'hA1; ram[8'hFD] = 8'hB2; ram[8'hFE] = 8'hC3; ram[8'hFF] = 8'hD4;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_dout_addr", {24'd0, dout_addr}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);

    r0 = rd_cnt; d0 = done_cnt;
    run_dump(8'h00, 7'd2);
    chk("basic_rd_count", rd_cnt - r0, 8);
    chk("basic_done_count", done_cnt - d0, 1);
    chk("basic_idle", {31'd0, busy}, 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("checksum", checksum, 32'h668899CC);
`endif

    r0 = rd_cnt;
    run_dump(8'h03, 7'd1);
    chk("unaligned_rd_count", rd_cnt - r0, 4);
    run_dump(8'hFC, 7'd2);

    dout_ready = 1'b0;
    expect_words(8'h10, 1);
    pulse_start(8'h10, 7'd1);
    lat = 0;
    for (int c = 1; c <= 20 && !dout_valid; c++) @(negedge clk);
    chk("stall_valid_seen", {31'd0, dout_valid}, 32'd1);
    snap = dout;
    r0 = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, dout_valid}, 32'd1);
      chk("stall_dout", dout, snap);
    end
    chk("stall_no_rd", rd_cnt - r0, 0);
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    r0 = rd_cnt; d0 = done_cnt;
    pulse_start(8'h00, 7'd0);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("zero_done_once", {31'd0, done}, 32'd0);
    chk("zero_idle", {31'd0, busy}, 32'd0);
    chk("zero_no_rd", rd_cnt - r0, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    pulse_start(8'h04, 7'd2);
    repeat (2) @(posedge clk);
    #1 Reset = 1'b1;
    @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    chk("midrst_dout", dout, 32'd0);
    chk("midrst_dout_addr", {24'd0, dout_addr}, 32'd0);
    chk("midrst_mem_addr", {24'd0, mem_addr}, 32'd0);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);

    r0 = rd_cnt; d0 = done_cnt;
    expect_words(8'h20, 2);
    pulse_start(8'h20, 7'd2);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(8'h80, 7'd5);
    wait_done(400, lat);
    repeat (10) @(negedge clk);
    chk("busy_start_rd_count", rd_cnt - r0, 8);
    chk("busy_start_done_count", done_cnt - d0, 1);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
